// File: rtl/text_display_engine.sv
// Text-mode display engine: VGA timing, cell/glyph fetch pipeline,
// cursor overlay and 16-colour palette to 24-bit RGB.
module text_display_engine #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int CELL_W          = 8,
  parameter int CELL_H          = 16,
  parameter int X_ADDR_WIDTH    = 7,
  parameter int Y_ADDR_WIDTH    = 5,
  parameter int FONT_ADDR_WIDTH = 12,
  parameter int BLINK_FRAMES    = 30
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pix_en,
  input  logic [X_ADDR_WIDTH-1:0]    cursor_x,
  input  logic [Y_ADDR_WIDTH-1:0]    cursor_y,
  input  logic [1:0]                 cursor_mode,
  output logic [X_ADDR_WIDTH-1:0]    x_addr,
  output logic [Y_ADDR_WIDTH-1:0]    y_addr,
  input  logic [15:0]                cell_data,
  output logic [FONT_ADDR_WIDTH-1:0] font_addr,
  input  logic [CELL_W-1:0]          font_data,
  output logic                       vga_hs,
  output logic                       vga_vs,
  output logic                       vga_blankn,
  output logic [7:0]                 vga_r,
  output logic [7:0]                 vga_g,
  output logic [7:0]                 vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  localparam int CWB = $clog2(CELL_W);
  localparam int CHB = $clog2(CELL_H);
  localparam int PXW = (CWB > 0) ? CWB : 1;
  localparam int LYW = (CHB > 0) ? CHB : 1;
  localparam int FCW = $clog2(BLINK_FRAMES + 1);

  localparam logic [PXW-1:0] PX_MAX = PXW'(CELL_W - 1);
  localparam logic [LYW-1:0] LY_MAX = LYW'(CELL_H - 1);
  localparam logic [X_ADDR_WIDTH-1:0] X_LAST =
    X_ADDR_WIDTH'(H_ACTIVE / CELL_W - 1);
  localparam logic [Y_ADDR_WIDTH-1:0] Y_LAST =
    Y_ADDR_WIDTH'(V_ACTIVE / CELL_H - 1);

  logic [HW-1:0]  h_cnt;
  logic [VW-1:0]  v_cnt;
  logic [FCW-1:0] frame_cnt;
  logic           blink_phase;
  logic           h_end, v_end;

  logic                    h_act, v_act, act0, hs0, vs0;
  logic [X_ADDR_WIDTH-1:0] col0;
  logic [Y_ADDR_WIDTH-1:0] row0;
  logic [PXW-1:0]          px0;
  logic [LYW-1:0]          ly0;

  logic           act1, hs1, vs1;
  logic [PXW-1:0] px1;
  logic [LYW-1:0] ly1;

  logic                    act2, hs2, vs2;
  logic [PXW-1:0]          px2;
  logic [LYW-1:0]          ly2;
  logic [X_ADDR_WIDTH-1:0] x2;
  logic [Y_ADDR_WIDTH-1:0] y2;
  logic [3:0]              fg2, bg2;

  logic       cur_pos, ul_hit, blk_hit, glyph, pix_bit;
  logic [3:0] fg_e, bg_e, idx;
  logic [7:0] pal_r, pal_g, pal_b;

  function automatic logic [7:0] level(input logic hi, input logic lo);
    level = (hi ? 8'hAA : 8'h00) + (lo ? 8'h55 : 8'h00);
  endfunction

  assign h_end = h_cnt == HW'(H_TOTAL - 1);
  assign v_end = v_cnt == VW'(V_TOTAL - 1);

  always_comb begin
    h_act = h_cnt < HW'(H_ACTIVE);
    v_act = v_cnt < VW'(V_ACTIVE);
    act0  = h_act && v_act;
    hs0   = !((h_cnt >= HW'(H_ACTIVE + H_FP)) &&
              (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC)));
    vs0   = !((v_cnt >= VW'(V_ACTIVE + V_FP)) &&
              (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC)));
    col0  = h_act ? X_ADDR_WIDTH'(h_cnt >> CWB) : X_LAST;
    row0  = v_act ? Y_ADDR_WIDTH'(v_cnt >> CHB) : Y_LAST;
    px0   = PXW'(h_cnt & HW'(CELL_W - 1));
    ly0   = LYW'(v_cnt & VW'(CELL_H - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (pix_en) begin
      if (h_end) begin
        h_cnt <= '0;
        v_cnt <= v_end ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
      if (h_end && v_end) begin
        if (frame_cnt == FCW'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  // Sync pipeline resets high so no false pulse leaves during flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_addr    <= '0;
      y_addr    <= '0;
      px1       <= '0;
      ly1       <= '0;
      act1      <= 1'b0;
      hs1       <= 1'b1;
      vs1       <= 1'b1;
      font_addr <= '0;
      fg2       <= '0;
      bg2       <= '0;
      px2       <= '0;
      ly2       <= '0;
      x2        <= '0;
      y2        <= '0;
      act2      <= 1'b0;
      hs2       <= 1'b1;
      vs2       <= 1'b1;
    end else if (pix_en) begin
      x_addr    <= col0;
      y_addr    <= row0;
      px1       <= px0;
      ly1       <= ly0;
      act1      <= act0;
      hs1       <= hs0;
      vs1       <= vs0;
      font_addr <= (FONT_ADDR_WIDTH'(cell_data[7:0]) << CHB) |
                   FONT_ADDR_WIDTH'(ly1);
      fg2       <= cell_data[11:8];
      bg2       <= cell_data[15:12];
      px2       <= px1;
      ly2       <= ly1;
      x2        <= x_addr;
      y2        <= y_addr;
      act2      <= act1;
      hs2       <= hs1;
      vs2       <= vs1;
    end
  end

  always_comb begin
    cur_pos = (x2 == cursor_x) && (y2 == cursor_y);
    ul_hit  = 1'b0;
    blk_hit = 1'b0;
    case (cursor_mode)
      2'd1:    ul_hit  = cur_pos && blink_phase && (ly2 == LY_MAX);
      2'd2:    blk_hit = cur_pos && blink_phase;
      2'd3:    blk_hit = cur_pos;
      default: ;
    endcase
    glyph   = font_data[PX_MAX - px2];
    pix_bit = glyph | ul_hit;
    fg_e    = ul_hit ? 4'd7 : (blk_hit ? bg2 : fg2);
    bg_e    = blk_hit ? fg2 : bg2;
    idx     = pix_bit ? fg_e : bg_e;
    pal_r   = level(idx[2], idx[3]);
    pal_g   = level(idx[1], idx[3]);
    pal_b   = level(idx[0], idx[3]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_hs     <= 1'b1;
      vga_vs     <= 1'b1;
      vga_blankn <= 1'b0;
      vga_r      <= '0;
      vga_g      <= '0;
      vga_b      <= '0;
    end else if (pix_en) begin
      vga_hs     <= hs2;
      vga_vs     <= vs2;
      vga_blankn <= act2;
      vga_r      <= act2 ? pal_r : 8'h00;
      vga_g      <= act2 ? pal_g : 8'h00;
      vga_b      <= act2 ? pal_b : 8'h00;
    end
  end

endmodule
